// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types and constants for the
// two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int NUM_MASTERS      = 2;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int LINE_BITS        = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef logic [LINE_BITS-1:0] line_t;

  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(
    input logic idx
  );
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin winner select; a tie goes
// to the master that did not win last time.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_last_grant,
  output logic [NUM_MASTERS-1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (&i_req) o_grant = idx_to_onehot(~i_last_grant);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: ifetch/data masters onto one line-wide bus,
// one outstanding txn. MEM_BUS_ARBITER_PERF_EN adds counters.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_MASTERS-1:0]                 m_req_valid,
  output logic [NUM_MASTERS-1:0]                 m_req_ready,
  input  logic [NUM_MASTERS-1:0]                 m_req_write,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_req_addr,
  input  logic [NUM_MASTERS-1:0][LINE_WIDTH-1:0] m_req_data,
  output logic [NUM_MASTERS-1:0]                 m_rsp_valid,
  output logic [LINE_WIDTH-1:0]                  m_rsp_data,
  output logic                                   bus_req_valid,
  input  logic                                   bus_req_ready,
  output logic                                   bus_req_write,
  output logic [ADDR_WIDTH-1:0]                  bus_req_addr,
  output logic [LINE_WIDTH-1:0]                  bus_req_data,
  input  logic                                   bus_rsp_valid,
  input  logic [LINE_WIDTH-1:0]                  bus_rsp_data
`ifdef MEM_BUS_ARBITER_PERF_EN
  ,
  output logic [NUM_MASTERS-1:0][31:0]           perf_grants,
  output logic [NUM_MASTERS-1:0][31:0]           perf_stall_cycles
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic                   r_last_grant;
  logic                   r_owner;
  logic                   r_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_data;
  logic [NUM_MASTERS-1:0] r_rsp_valid;
  logic [LINE_WIDTH-1:0]  r_rsp_data;

  logic [NUM_MASTERS-1:0] w_grant;
  logic [NUM_MASTERS-1:0] w_ready;
  logic                   w_idx;
  logic                   w_accept;
  logic                   w_rsp_take;
  logic                   w_unused;

  rr_arbiter2 u_rr (
    .i_req        (m_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_idx = w_grant[1];

  // Line offset bits are dropped on latch.
  assign w_unused = ^{m_req_addr[0][LINE_OFFSET_BITS-1:0],
                      m_req_addr[1][LINE_OFFSET_BITS-1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_rsp_take  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|m_req_valid && !reset) begin
          w_ready     = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_req_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_idx;
      r_owner      <= w_idx;
      r_write      <= m_req_write[w_idx];
      r_addr       <= {m_req_addr[w_idx][ADDR_WIDTH-1:LINE_OFFSET_BITS],
                       {LINE_OFFSET_BITS{1'b0}}};
      r_data       <= m_req_data[w_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_take ? idx_to_onehot(r_owner) : '0;
      if (w_rsp_take) r_rsp_data <= bus_rsp_data;
    end
  end

  assign m_req_ready   = w_ready;
  assign m_rsp_valid   = r_rsp_valid;
  assign m_rsp_data    = r_rsp_data;
  assign bus_req_valid = (r_state == ISSUE);
  assign bus_req_write = r_write;
  assign bus_req_addr  = r_addr;
  assign bus_req_data  = r_data;

`ifdef MEM_BUS_ARBITER_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_ready[i])
          perf_grants[i] <= perf_grants[i] + 32'd1;
        if (m_req_valid[i] && !w_ready[i])
          perf_stall_cycles[i] <= perf_stall_cycles[i] + 32'd1;
      end
    end
  end
`else
  // No counters in this build.
`endif

`ifndef SYNTHESIS
  // A response outside WAIT has no owner and is dropped.
  always @(posedge clock) begin
    if (!reset && bus_rsp_valid && r_state != WAIT)
      $warning("stray bus response outside WAIT dropped");
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random rounds checked
// against a transaction-level round-robin model.
module tb_mem_bus_arbiter;

  logic              clock;
  logic              reset;
  logic [1:0]        m_req_valid;
  logic [1:0]        m_req_ready;
  logic [1:0]        m_req_write;
  logic [1:0][31:0]  m_req_addr;
  logic [1:0][127:0] m_req_data;
  logic [1:0]        m_rsp_valid;
  logic [127:0]      m_rsp_data;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_write;
  logic [31:0]       bus_req_addr;
  logic [127:0]      bus_req_data;
  logic              bus_rsp_valid;
  logic [127:0]      bus_rsp_data;

  int n_pass;
  int n_total;
  int model_last;
  int w;
  logic [31:0] seen_addr;

  mem_bus_arbiter #(
    .ADDR_WIDTH (32),
    .LINE_WIDTH (128)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_write   (m_req_write),
    .m_req_addr    (m_req_addr),
    .m_req_data    (m_req_data),
    .m_rsp_valid   (m_rsp_valid),
    .m_rsp_data    (m_rsp_data),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_data  (bus_req_data),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Tie goes to the master that did not win last; else sole one.
  function int pick(input logic [1:0] v);
    int r;
    if (v == 2'b11) r = 1 - model_last;
    else            r = v[1] ? 1 : 0;
    model_last = r;
    return r;
  endfunction

  task automatic set_m(input int i, input logic wr,
                       input logic [31:0] a,
                       input logic [127:0] d);
    m_req_write[i] = wr;
    m_req_addr[i]  = a;
    m_req_data[i]  = d;
  endtask

  task automatic do_round(input logic [1:0] vld,
                          input int rdy_dly,
                          input int rsp_dly,
                          input logic [127:0] rdata,
                          output int winner);
    int wi;
    logic [31:0] ea;
    logic [127:0] ed;
    logic ew;
    m_req_valid = vld;
    wi = pick(vld);
    #1;
    check("req_ready", m_req_ready, onehot(wi));
    ea = m_req_addr[wi] & ~32'hF;
    ew = m_req_write[wi];
    ed = m_req_data[wi];
    @(negedge clock);
    m_req_valid[wi] = 1'b0;
    #1;
    for (int i = 0; i < rdy_dly; i++) begin
      check("issue_valid", bus_req_valid, 1);
      check("issue_addr", bus_req_addr, ea);
      check("issue_busy", m_req_ready, 0);
      @(negedge clock);
      #1;
    end
    check("bus_valid", bus_req_valid, 1);
    check("bus_addr", bus_req_addr, ea);
    check("bus_write", bus_req_write, ew);
    check("bus_data", bus_req_data, ed);
    seen_addr = bus_req_addr;
    bus_req_ready = 1'b1;
    @(negedge clock);
    bus_req_ready = 1'b0;
    #1;
    check("wait_valid", bus_req_valid, 0);
    for (int i = 0; i < rsp_dly; i++) begin
      check("wait_rsp", m_rsp_valid, 0);
      check("wait_busy", m_req_ready, 0);
      @(negedge clock);
      #1;
    end
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = rdata;
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("rsp_valid", m_rsp_valid, onehot(wi));
    check("rsp_data", m_rsp_data, rdata);
    winner = wi;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_last = 1;
  endtask

  initial begin
    clock = 0;
    reset = 1;
    m_req_valid = '0;
    m_req_write = '0;
    m_req_addr = '0;
    m_req_data = '0;
    bus_req_ready = 0;
    bus_rsp_valid = 0;
    bus_rsp_data = '0;
    n_pass = 0;
    n_total = 0;
    model_last = 1;
    #3;
    check("rst_bus_valid", bus_req_valid, 0);
    check("rst_bus_addr", bus_req_addr, 0);
    check("rst_rsp_valid", m_rsp_valid, 0);
    check("rst_ready", m_req_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;

    // single read
    set_m(0, 0, 32'h1000, '0);
    do_round(2'b01, 0, 2,
             {32'h3, 32'h2, 32'h1, 32'h0}, w);
    check("read_addr", seen_addr, 32'h1000);

    // stray response while idle
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 128'hBAD;
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    #1;
    check("stray_rsp", m_rsp_valid, 0);
    check("stray_bus", bus_req_valid, 0);
    set_m(1, 0, 32'h3000, '0);
    do_round(2'b10, 0, 0, 128'h55, w);
    check("stray_idle", w, 1);

    // tie after reset alternates 0,1,0,1
    pulse_reset();
    set_m(0, 0, 32'h1000, '0);
    set_m(1, 0, 32'h1810, '0);
    for (int k = 0; k < 4; k++) begin
      do_round(2'b11, 0, 1, {4{32'h100 + k}}, w);
      check("tie_seq", w, k % 2);
      if (k == 1) check("tie_addr1", seen_addr, 32'h1810);
    end

    // write with slow bus ready
    m_req_valid = '0;
    set_m(1, 1, 32'h1800, 128'hDEADBEEF);
    do_round(2'b10, 5, 1, 128'h0, w);
    check("write_owner", w, 1);

    // unaligned address
    set_m(0, 0, 32'h101C, 128'h7);
    do_round(2'b01, 0, 0, 128'h99, w);
    check("unaligned", seen_addr, 32'h1010);

    // random rounds
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++)
        if (!m_req_valid[i])
          set_m(i, 1'($urandom),
                $urandom,
                {$urandom, $urandom, $urandom, $urandom});
      do_round(2'($urandom_range(1, 3)),
               $urandom_range(0, 3),
               $urandom_range(0, 3),
               {$urandom, $urandom, $urandom, $urandom}, w);
    end

    // reset in the middle of WAIT
    m_req_valid = '0;
    @(negedge clock);
    set_m(0, 1, 32'h2040, {4{32'hA5A5_0001}});
    m_req_valid = 2'b01;
    @(negedge clock);
    m_req_valid = 2'b00;
    bus_req_ready = 1'b1;
    @(negedge clock);
    bus_req_ready = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_bus_valid", bus_req_valid, 0);
    check("mrst_addr", bus_req_addr, 0);
    check("mrst_write", bus_req_write, 0);
    check("mrst_data", bus_req_data, 0);
    check("mrst_rsp_valid", m_rsp_valid, 0);
    check("mrst_rsp_data", m_rsp_data, 0);
    check("mrst_ready", m_req_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    model_last = 1;
    set_m(0, 0, 32'h4000, '0);
    set_m(1, 0, 32'h5000, '0);
    do_round(2'b11, 0, 0, 128'h1234, w);
    check("mrst_tie", w, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
